// File: rtl/imem_loader.sv
// imem_loader
// Boot loader that streams an instruction image from a byte interface into
// instruction memory while holding the CPU pipeline in reset.
//
// Image format (all big-endian):
//   N[15:8], N[7:0]        word count header, 1 <= N <= 2^ADDR_W
//   4*N data bytes         instruction words, most significant byte first
//   1 checksum byte        XOR of all data bytes
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   start       one-cycle pulse, begins a load from IDLE/DONE/ERR
//   byte_valid  byte stream valid
//   byte_data   byte stream data
//   byte_ready  loader accepts a byte this cycle
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   write address, BASE_ADDR + word index (wraps mod 2^ADDR_W)
//   imem_wdata  write data
//   cpu_hold    pipeline held in reset while high (low only in DONE)
//   load_done   image loaded and checksum verified
//   err         00 none, 01 bad length, 10 checksum mismatch
//   word_count  words written in the current load
//
// state  | meaning
// IDLE   | after reset, waiting for start
// HDR_HI | waiting for word count high byte
// HDR_LO | waiting for word count low byte, length check
// DATA   | collecting instruction bytes, one write per 4 bytes
// CHK    | waiting for checksum byte
// DONE   | image verified, CPU released
// ERR    | load failed, err holds the cause

module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [1:0]        err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [31:0]       MAX_WORDS = 32'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W+1)'(1);

  state_t            state, state_nxt;
  logic              accept;
  logic [7:0]        len_hi;
  logic [15:0]       len_full;
  logic              len_bad;
  logic [ADDR_W:0]   words_left;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [7:0]        checksum;
  logic [ADDR_W-1:0] wr_addr;
  logic              last_byte;
  logic              last_word;

  assign accept    = byte_valid & byte_ready;
  assign len_full  = {len_hi, byte_data};
  assign len_bad   = (len_full == 16'd0) || ({16'd0, len_full} > MAX_WORDS);
  assign last_byte = (byte_idx == 2'd3);
  // words_left is a down-counter loaded with N; terminal count is the
  // word being completed while it still reads 1.
  assign last_word = (words_left == ONE_WORD);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = HDR_HI;
      HDR_HI:          if (accept) state_nxt = HDR_LO;
      HDR_LO:          if (accept) state_nxt = len_bad ? ERR : DATA;
      DATA:            if (accept && last_byte && last_word) state_nxt = CHK;
      CHK:             if (accept) state_nxt = (byte_data == checksum) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    case (state)
      HDR_HI, HDR_LO, DATA, CHK: byte_ready = 1'b1;
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      default: ;
    endcase
  end

  // datapath: header capture, word assembly, writes, checksum, error code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 2'b00;
      word_count <= '0;
      checksum   <= '0;
      len_hi     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      wr_addr    <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            err        <= 2'b00;
            word_count <= '0;
            checksum   <= '0;
            byte_idx   <= '0;
            wr_addr    <= BASE;
          end
        end
        HDR_HI: if (accept) len_hi <= byte_data;
        HDR_LO: begin
          if (accept) begin
            words_left <= (ADDR_W+1)'(len_full);
            if (len_bad) err <= 2'b01;
          end
        end
        DATA: begin
          if (accept) begin
            checksum <= checksum ^ byte_data;
            byte_idx <= byte_idx + 2'd1;
            word_buf <= {word_buf[15:0], byte_data};
            if (last_byte) begin
              imem_we    <= 1'b1;
              imem_wdata <= {word_buf, byte_data};
              imem_addr  <= wr_addr;
              wr_addr    <= wr_addr + 1'b1;
              word_count <= word_count + 1'b1;
              words_left <= words_left - 1'b1;
            end
          end
        end
        CHK: if (accept && (byte_data != checksum)) err <= 2'b10;
        default: ;
      endcase
    end
  end

endmodule
